riscv_if: RTL and testbench
===========================

Name: riscv_if

Overview:
- Instruction-fetch stage of the RISC-V core; it is the producer side of the decode stage's `pc_i`/`inst_i` interface.
- Holds the PC and issues one-outstanding requests to instruction memory.
- Buffers returned words in a small FIFO and presents `{pc, inst}` to decode with a valid/ready handshake.
- Consumes the branch outcome from execute (br, zero_en, ALU zero, offset); on a taken branch it redirects the PC and flushes all younger fetch state.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, fetch buffer entries (power of two, >= 2).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  32  request address (word aligned).
- imem_ack_i  in  1  response strobe; imem_rdata_i is valid in this cycle.
- imem_rdata_i  in  32  fetched instruction word.
- inst_valid_o  out  1  FIFO head valid.
- inst_o  out  32  FIFO head instruction; 32'h0000_0013 (NOP) when empty.
- pc_o  out  32  FIFO head PC; 0 when empty.
- id_ready_i  in  1  decode accepts head this cycle.
- ex_br_i  in  1  execute holds a branch/jump.
- ex_zero_en_i  in  1  branch polarity from decode.
- ex_alu_zero_i  in  1  ALU result == 0.
- ex_pc_i  in  32  PC of the branch.
- ex_offset_i  in  32  branch/jump offset (jalr already rebased to pc).
- flush_o  out  1  combinational; equals taken, tells ID/EX to squash.

Behaviour:
- Branch taken = ex_br_i & (ex_alu_zero_i == ex_zero_en_i).
- Target = (ex_pc_i + ex_offset_i) with bits [1:0] forced to 0. The add is 32-bit and wraps modulo 2^32.
- Reset values:
  - pc = RESET_PC, FIFO count = 0, state = IDLE.
  - imem_req_o = 0, imem_addr_o = RESET_PC, inst_valid_o = 0, inst_o = NOP, pc_o = 0.
- imem_addr_o always equals the pc register. imem_req_o = 1 in states FETCH and DROP, else 0.
- Memory protocol:
  - Request and address are held stable until the ack cycle; the ack may come in the same cycle as the request or any later cycle.
  - At most one request is outstanding.
  - imem_ack_i in IDLE is ignored.
- State machine (priority: rst > taken > ack):
  - IDLE -> FETCH when count < FIFO_DEPTH, or on taken (pc <- target).
  - FETCH, ack without taken:
    - push {pc, rdata} and pc <- pc + 4;
    - next state FETCH if the post-push/pop count < FIFO_DEPTH, else IDLE.
  - FETCH, taken without ack: pc held (address must stay stable) and the target is latched in redirect_pc; -> DROP.
  - FETCH, taken with ack: data discarded, pc <- target; -> FETCH.
  - DROP, ack: data discarded, pc <- redirect_pc; -> FETCH.
  - DROP, taken again: redirect_pc <- new target; remain DROP, or -> FETCH with pc <- new target if ack is in the same cycle.
- FIFO:
  - Pop when inst_valid_o & id_ready_i.
  - Push and pop in the same cycle leave count unchanged.
  - Head outputs are combinational from storage; pointers wrap modulo FIFO_DEPTH.
- Flush: on taken, count <- 0 and both pointers reset. Any pop or push in that cycle is discarded; decode is squashed by flush_o.
- Latency:
  - With zero-wait memory (ack in the request cycle), the first instruction appears on inst_valid_o two cycles after rst deasserts.
  - Sustained throughput is 1 instruction/cycle while decode is ready.
- Full FIFO: no request issued; pc holds; inst_valid_o remains 1 until popped.
- pc + 4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- rst mid-request: state returns to IDLE immediately and any later ack for the old request is ignored. The memory is reset alongside the core.

Test Plan:
- Reset, zero-wait memory returning addr^32'hA5A5_0000, id_ready_i=1 -> pc_o sequence 0, 4, 8, 12 on consecutive cycles with matching inst_o; first valid two cycles after rst low.
- id_ready_i=0 for 6 cycles -> exactly FIFO_DEPTH (2) entries buffered (pc 0, 4); imem_req_o drops to 0; releasing ready yields 0, 4, 8 with no gap or duplicate.
- beq taken (ex_br_i=1, ex_zero_en_i=1, ex_alu_zero_i=1, ex_pc_i=0x10, ex_offset_i=0x20) with FIFO holding 2 entries -> flush_o=1 that cycle, inst_valid_o=0 next cycle, next fetch address 0x30.
- Memory latency 3 cycles, bne taken (zero_en=0, alu_zero=0, pc 0x40, offset -8) in cycle 1 of an outstanding request to 0x44:
  - imem_addr_o stays 0x44 until ack;
  - that word is never pushed;
  - next request is to 0x38.
- Not-taken bge-style (zero_en=1, alu_zero=0) and br_i=0 with zero_en==alu_zero -> flush_o=0, PC stream unaffected.
- rst asserted while FETCH outstanding, late ack arriving in IDLE -> no push; fetch restarts at RESET_PC; FIFO empty.

Source files
------------

// File: rtl/riscv_if.sv
// riscv_if -- instruction-fetch stage.
//
// Holds the fetch PC and keeps at most one request to instruction memory
// outstanding. Returned words are queued in a small FIFO and presented to
// decode as {pc_o, inst_o} under a valid/ready handshake. A taken branch from
// execute redirects the PC, empties the FIFO and squashes ID/EX via flush_o.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   imem_req_o/imem_addr_o   memory request and word address (== pc register)
//   imem_ack_i/imem_rdata_i  response strobe and returned instruction word
//   inst_valid_o/inst_o/pc_o FIFO head towards decode (NOP / 0 when empty)
//   id_ready_i               decode accepts the head this cycle
//   ex_br_i, ex_zero_en_i,
//   ex_alu_zero_i, ex_pc_i,
//   ex_offset_i              branch outcome and target inputs from execute
//   flush_o                  branch taken this cycle (combinational)
module riscv_if #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        id_ready_i,
  input  logic        ex_br_i,
  input  logic        ex_zero_en_i,
  input  logic        ex_alu_zero_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_offset_i,
  output logic        flush_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // IDLE: no request. FETCH: request live, data will be kept.
  // DROP: request live, but a redirect arrived; its data will be discarded.
  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]      fifo_inst_q [FIFO_DEPTH];

  logic             taken;
  logic [31:0]      target;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_after;
  logic [FIFO_DEPTH-1:0] wr_en;

  assign taken  = ex_br_i & (ex_alu_zero_i == ex_zero_en_i);
  assign target = (ex_pc_i + ex_offset_i) & 32'hFFFF_FFFC;

  // Only a FETCH-state ack delivers useful data; a simultaneous redirect
  // makes that word stale.
  assign push = (state_q == FETCH) & imem_ack_i & ~taken;
  assign pop  = inst_valid_o & id_ready_i;

  assign imem_req_o   = (state_q != IDLE);
  assign imem_addr_o  = pc_q;
  assign flush_o      = taken;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? fifo_inst_q[rd_ptr_q] : NOP;
  assign pc_o         = inst_valid_o ? fifo_pc_q[rd_ptr_q] : 32'h0000_0000;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    count_after   = count_q + CNT_W'(push) - CNT_W'(pop);
    count_d       = count_after;

    if (taken) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    case (state_q)
      IDLE: begin
        // Resuming on the post-pop count lets a full FIFO restart fetching
        // in the same cycle decode frees a slot, avoiding a bubble.
        if (taken) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (count_after < CNT_W'(FIFO_DEPTH)) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (taken) begin
          if (imem_ack_i) begin
            pc_d = target;
          end else begin
            // Address must stay stable until the ack; park the target.
            redirect_pc_d = target;
            state_d       = DROP;
          end
        end else if (imem_ack_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = (count_after < CNT_W'(FIFO_DEPTH)) ? FETCH : IDLE;
        end
      end
      DROP: begin
        if (taken) begin
          if (imem_ack_i) begin
            pc_d    = target;
            state_d = FETCH;
          end else begin
            redirect_pc_d = target;
          end
        end else if (imem_ack_i) begin
          pc_d    = redirect_pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push & (wr_ptr_q == PTR_W'(gi));
  end

  // Storage needs no reset: the head is masked by the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (wr_en[i]) begin
        fifo_pc_q[i]   <= pc_q;
        fifo_inst_q[i] <= imem_rdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      redirect_pc_q <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_riscv_if.sv
// tb_riscv_if -- self-checking bench for riscv_if.
// A queue-based reference model predicts every output each cycle; a memory
// model returns addr ^ 32'hA5A5_0000 after a configurable latency.
module tb_riscv_if;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] MASK   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid;
  logic [31:0] inst, pc;
  logic        id_ready = 1'b0;
  logic        ex_br = 1'b0, ex_zero_en = 1'b0, ex_alu_zero = 1'b0;
  logic [31:0] ex_pc = '0, ex_offset = '0;
  logic        flush;

  int n_cmp = 0;
  int n_bad = 0;

  // memory model state
  int   mem_cnt = 0, mem_lat = 0, mem_cnt_n = 0, mem_lat_n = 0;
  int   lat_lo = 0, lat_hi = 0;
  logic stray = 1'b0;

  // reference model state
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_redir = RST_PC;
  bit          m_busy = 1'b0;
  bit          m_drop = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    imem_ack   = (imem_req && (mem_cnt >= mem_lat)) || stray;
    imem_rdata = imem_addr ^ MASK;
  end

  riscv_if #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .inst_valid_o(inst_valid), .inst_o(inst), .pc_o(pc),
    .id_ready_i(id_ready),
    .ex_br_i(ex_br), .ex_zero_en_i(ex_zero_en), .ex_alu_zero_i(ex_alu_zero),
    .ex_pc_i(ex_pc), .ex_offset_i(ex_offset),
    .flush_o(flush)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_taken();
    return ex_br && (ex_alu_zero == ex_zero_en);
  endfunction

  task automatic compare_all();
    chk("req", {31'd0, imem_req}, {31'd0, m_busy});
    chk("addr", imem_addr, m_pc);
    chk("valid", {31'd0, inst_valid}, {31'd0, q.size() != 0});
    chk("inst", inst, (q.size() != 0) ? q[0].inst : NOP);
    chk("pc", pc, (q.size() != 0) ? q[0].pc : 32'h0);
    chk("flush", {31'd0, flush}, {31'd0, model_taken()});
  endtask

  // One clock's worth of the fetch rules, applied to the values present
  // just before the rising edge.
  task automatic step();
    bit          tk, pp;
    logic [31:0] tgt;
    tk  = model_taken();
    tgt = (ex_pc + ex_offset) & 32'hFFFF_FFFC;

    mem_cnt_n = mem_cnt;
    mem_lat_n = mem_lat;
    if (rst) begin
      mem_cnt_n = 0;
      mem_lat_n = int'($urandom_range(lat_hi, lat_lo));
    end else if (imem_req) begin
      if (imem_ack) begin
        mem_cnt_n = 0;
        mem_lat_n = int'($urandom_range(lat_hi, lat_lo));
      end else begin
        mem_cnt_n = mem_cnt + 1;
      end
    end

    if (rst) begin
      q.delete();
      m_pc = RST_PC; m_redir = RST_PC; m_busy = 1'b0; m_drop = 1'b0;
    end else if (tk) begin
      q.delete();
      if (!m_busy || imem_ack) begin
        m_pc = tgt; m_busy = 1'b1; m_drop = 1'b0;
      end else begin
        m_redir = tgt; m_drop = 1'b1;
      end
    end else begin
      pp = (q.size() != 0) && id_ready;
      if (pp) void'(q.pop_front());
      if (!m_busy) begin
        m_busy = (q.size() < DEPTH);
      end else if (imem_ack) begin
        if (m_drop) begin
          m_pc = m_redir; m_drop = 1'b0;
        end else begin
          q.push_back({m_pc, m_pc ^ MASK});
          m_pc   = m_pc + 32'd4;
          m_busy = (q.size() < DEPTH);
        end
      end
    end
  endtask

  // compare process: outputs checked on the falling edge, model advanced
  // just before the rising edge, memory counters committed after it
  initial begin
    forever begin
      @(negedge clk);
      compare_all();
      #3;
      step();
      @(posedge clk);
      #1;
      mem_cnt = mem_cnt_n;
      mem_lat = mem_lat_n;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_br(input logic br, input logic zen, input logic az,
                        input logic [31:0] bpc, input logic [31:0] off);
    ex_br = br; ex_zero_en = zen; ex_alu_zero = az; ex_pc = bpc; ex_offset = off;
  endtask

  initial begin
    // zero-wait stream from reset
    lat_lo = 0; lat_hi = 0; id_ready = 1'b1;
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("lat1_valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("lat2_valid", {31'd0, inst_valid}, 32'd1);
    chk("seq_pc0", pc, 32'h0);
    chk("seq_inst0", inst, 32'hA5A5_0000);
    tick(); chk("seq_pc4", pc, 32'h4); chk("seq_inst4", inst, 32'hA5A5_0004);
    tick(); chk("seq_pc8", pc, 32'h8);
    tick(); chk("seq_pc12", pc, 32'hC); chk("seq_inst12", inst, 32'hA5A5_000C);

    // decode stalled: FIFO fills to DEPTH and fetching stops
    id_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("full_valid", {31'd0, inst_valid}, 32'd1);
    chk("full_pc", pc, 32'h0);
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_addr", imem_addr, 32'h8);
    id_ready = 1'b1;
    tick(); chk("drain_pc4", pc, 32'h4);
    tick(); chk("drain_pc8", pc, 32'h8);

    // beq taken with a full FIFO
    id_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    set_br(1'b1, 1'b1, 1'b1, 32'h10, 32'h20);
    #1;
    chk("beq_flush", {31'd0, flush}, 32'd1);
    tick();
    ex_br = 1'b0;
    chk("beq_valid", {31'd0, inst_valid}, 32'd0);
    chk("beq_addr", imem_addr, 32'h30);
    chk("beq_req", {31'd0, imem_req}, 32'd1);

    // 3-cycle memory, bne taken while the request to 0x44 is pending
    lat_lo = 3; lat_hi = 3; id_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    set_br(1'b1, 1'b1, 1'b1, 32'h40, 32'h4);
    tick();
    ex_br = 1'b0;
    chk("slow_addr0", imem_addr, 32'h44);
    tick();
    set_br(1'b1, 1'b0, 1'b0, 32'h40, 32'hFFFF_FFF8);
    #1;
    chk("bne_flush", {31'd0, flush}, 32'd1);
    tick();
    ex_br = 1'b0;
    chk("hold_addr2", imem_addr, 32'h44);
    chk("hold_req2", {31'd0, imem_req}, 32'd1);
    tick(); chk("hold_addr3", imem_addr, 32'h44);
    tick();
    chk("redir_addr", imem_addr, 32'h38);
    chk("redir_valid", {31'd0, inst_valid}, 32'd0);
    repeat (4) tick();
    chk("redir_pc", pc, 32'h38);
    chk("redir_inst", inst, 32'hA5A5_0038);

    // not-taken branches
    set_br(1'b1, 1'b1, 1'b0, 32'h100, 32'h40);
    #1;
    chk("bge_nt_flush", {31'd0, flush}, 32'd0);
    tick();
    set_br(1'b0, 1'b1, 1'b1, 32'h100, 32'h40);
    #1;
    chk("nobr_flush", {31'd0, flush}, 32'd0);
    tick();

    // reset with a request outstanding, stray ack in IDLE afterwards
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; stray = 1'b1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd0);
    tick();
    stray = 1'b0;
    chk("restart_addr", imem_addr, RST_PC);
    chk("restart_valid", {31'd0, inst_valid}, 32'd0);
    repeat (3) tick();

    // PC wrap at the top of the address space
    lat_lo = 0; lat_hi = 0; rst = 1'b1;
    tick();
    rst = 1'b0;
    set_br(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'hC);
    tick();
    ex_br = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr0", imem_addr, 32'h0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_inst", inst, 32'h5A5A_FFFC);
    tick();
    chk("wrap_pc0", pc, 32'h0);

    // randomized traffic
    lat_lo = 0; lat_hi = 3;
    repeat (4000) begin
      tick();
      rst         = ($urandom_range(99) == 0);
      id_ready    = ($urandom_range(3) != 0);
      ex_br       = ($urandom_range(9) == 0);
      ex_zero_en  = 1'($urandom_range(1));
      ex_alu_zero = 1'($urandom_range(1));
      ex_pc       = $urandom;
      ex_offset   = ($urandom_range(1) == 1) ? $urandom : (32'($urandom_range(64)) - 32'd32);
      stray       = !m_busy && ($urandom_range(4) == 0);
    end
    tick();
    ex_br = 1'b0; stray = 1'b0; rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
